// File: rtl/amp_variable_pkg.sv
// amp_variable_pkg: shared widths, FSM state type and Q4.4 gain constants for the variable-gain amplifier.
package amp_variable_pkg;
    localparam int DEF_BIT_WIDTH  = 10;
    localparam int DEF_GAIN_WIDTH = 8;
    localparam int DEF_GAIN_FRAC  = 4;
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
    localparam logic [7:0] GAIN_X0_5 = 8'h08;
    localparam logic [7:0] GAIN_X1   = 8'h10;
    localparam logic [7:0] GAIN_X1_5 = 8'h18;
    localparam logic [7:0] GAIN_X2   = 8'h20;
    localparam logic [7:0] GAIN_X4   = 8'h40;
endpackage

// File: rtl/seq_umul.sv
// seq_umul: unsigned LSB-first shift-add multiplier, one multiplier bit per cycle.
module seq_umul #(
    parameter int A_WIDTH = 10,
    parameter int B_WIDTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic [A_WIDTH-1:0]         a_i,
    input  logic [B_WIDTH-1:0]         b_i,
    output logic                       done_o,
    output logic [A_WIDTH+B_WIDTH-1:0] prod_o
);
    localparam int PW = A_WIDTH + B_WIDTH;
    localparam int CW = $clog2(B_WIDTH + 1);
    logic              run_q;
    logic [CW-1:0]     cnt_q;
    logic [PW-1:0]     a_q, acc_q;
    logic [B_WIDTH-1:0] b_q;
    assign done_o = run_q && (cnt_q == CW'(B_WIDTH - 1));
    assign prod_o = acc_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            run_q <= 1'b0;
            cnt_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else if (start_i) begin
            run_q <= 1'b1;
            cnt_q <= '0;
            a_q   <= PW'(a_i);
            b_q   <= b_i;
            acc_q <= '0;
        end else if (run_q) begin
            acc_q <= acc_q + (b_q[0] ? a_q : '0);
            a_q   <= a_q << 1;
            b_q   <= b_q >> 1;
            cnt_q <= cnt_q + CW'(1);
            run_q <= !done_o;
        end
    end
endmodule

// File: rtl/amp_variable.sv
// amp_variable: runtime-programmable signed gain stage with saturation and clip flag.
module amp_variable
    import amp_variable_pkg::*;
#(
    parameter int BIT_WIDTH  = DEF_BIT_WIDTH,
    parameter int GAIN_WIDTH = DEF_GAIN_WIDTH,
    parameter int GAIN_FRAC  = DEF_GAIN_FRAC
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  gain_wr_i,
    input  logic [GAIN_WIDTH-1:0] gain_data_i,
    input  logic                  in_stb_i,
    input  logic [BIT_WIDTH-1:0]  in_i,
    output logic                  busy_o,
    output logic                  out_stb_o,
    output logic [BIT_WIDTH-1:0]  out_o,
    output logic                  clip_o
);
    localparam int AW = BIT_WIDTH + GAIN_WIDTH;
    localparam int RW = AW - GAIN_FRAC;
    state_t                state_q;
    logic                  sign_q, clip_q, out_stb_q, clip_d, start, mul_done;
    logic [GAIN_WIDTH-1:0] gain_q;
    logic [BIT_WIDTH-1:0]  out_q, out_d, mag;
    logic [AW-1:0]         prod;
    logic [RW-1:0]         r;
    assign start = (state_q == IDLE) && in_stb_i;
    assign mag   = in_i[BIT_WIDTH-1] ? -in_i : in_i;
    assign r     = RW'(prod >> GAIN_FRAC);
    // A freshly written gain wins over the pending one when it arrives with the accepted sample.
    seq_umul #(.A_WIDTH(BIT_WIDTH), .B_WIDTH(GAIN_WIDTH)) u_mul (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start),
        .a_i     (mag),
        .b_i     (gain_wr_i ? gain_data_i : gain_q),
        .done_o  (mul_done),
        .prod_o  (prod)
    );
    // Negative full scale is one step larger than positive, hence the asymmetric limits.
    always_comb begin
        clip_d = sign_q ? (r > RW'(2 ** (BIT_WIDTH - 1))) : (r > RW'(2 ** (BIT_WIDTH - 1) - 1));
        out_d  = clip_d ? {sign_q, {(BIT_WIDTH - 1){~sign_q}}} : (sign_q ? BIT_WIDTH'(-r) : BIT_WIDTH'(r));
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            sign_q    <= 1'b0;
            gain_q    <= GAIN_WIDTH'(1 << GAIN_FRAC);
            out_q     <= '0;
            clip_q    <= 1'b0;
            out_stb_q <= 1'b0;
        end else begin
            out_stb_q <= 1'b0;
            if (gain_wr_i) gain_q <= gain_data_i;
            case (state_q)
                IDLE: if (in_stb_i) begin
                    sign_q  <= in_i[BIT_WIDTH-1];
                    state_q <= MUL;
                end
                MUL: if (mul_done) state_q <= DONE;
                DONE: begin
                    out_q     <= out_d;
                    clip_q    <= clip_d;
                    out_stb_q <= 1'b1;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign busy_o    = state_q != IDLE;
    assign out_stb_o = out_stb_q;
    assign out_o     = out_q;
    assign clip_o    = clip_q;
endmodule

// File: tb/tb_amp_variable.sv
// tb_amp_variable: vector table, corner sequences and randomized max-rate run against an arithmetic model.
module tb_amp_variable;
    logic       clk = 0, rst = 1, gain_wr = 0, in_stb = 0;
    logic [7:0] gain_data = 0;
    logic [9:0] in_v = 0, out_v;
    logic       busy, out_stb, clip;
    int         checks = 0, errors = 0, stb_cnt = 0;

    amp_variable dut (
        .clk_i(clk), .rst_i(rst), .gain_wr_i(gain_wr), .gain_data_i(gain_data),
        .in_stb_i(in_stb), .in_i(in_v), .busy_o(busy), .out_stb_o(out_stb),
        .out_o(out_v), .clip_o(clip)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (out_stb) stb_cnt++;

    typedef struct packed {
        logic [1:0] mode;
        logic [7:0] g;
        logic [9:0] x;
        logic [9:0] o;
        logic       c;
    } vec_t;
    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void ref_amp(input logic [9:0] x, input logic [7:0] g,
                                    output logic [9:0] o, output logic c);
        int v, m, r;
        v = $signed(x);
        m = v < 0 ? -v : v;
        r = (m * int'(g)) / 16;
        c = 1'b0;
        if (v >= 0 && r > 511) begin o = 10'h1FF; c = 1'b1; end
        else if (v < 0 && r > 512) begin o = 10'h200; c = 1'b1; end
        else o = 10'(v < 0 ? -r : r);
    endfunction

    task automatic wait_out(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_stb && n < 30);
    endtask

    task automatic write_gain(input logic [7:0] g);
        @(negedge clk);
        gain_wr = 1; gain_data = g;
        @(negedge clk);
        gain_wr = 0;
    endtask

    // mode 0: pending gain, 1: gain written with the sample, 2: gain written beforehand
    task automatic apply(input vec_t v, input string name);
        int n;
        if (v.mode == 2) write_gain(v.g);
        @(negedge clk);
        in_stb = 1; in_v = v.x; gain_wr = (v.mode == 1); gain_data = v.g;
        @(negedge clk);
        in_stb = 0; gain_wr = 0;
        wait_out(n);
        check({name, "_lat"}, n, 9);
        check({name, "_out"}, out_v, v.o);
        check({name, "_clip"}, clip, v.c);
    endtask

    initial begin
        int n, base, cnt;
        logic stb_exp, ec, s, w, c_chk;
        logic [9:0] eo, x;
        logic [7:0] pend, gd;
        vecs = '{
            '{2'd0, 8'h10, 10'h1FF, 10'h1FF, 1'b0},
            '{2'd1, 8'h18, 10'h39C, 10'h36A, 1'b0},
            '{2'd2, 8'h08, 10'h3FD, 10'h3FF, 1'b0},
            '{2'd1, 8'h20, 10'h12C, 10'h1FF, 1'b1},
            '{2'd0, 8'h20, 10'h200, 10'h200, 1'b1},
            '{2'd2, 8'h10, 10'h200, 10'h200, 1'b0},
            '{2'd1, 8'h00, 10'h155, 10'h000, 1'b0},
            '{2'd1, 8'hFF, 10'h3FF, 10'h3F1, 1'b0},
            '{2'd1, 8'h08, 10'h001, 10'h000, 1'b0},
            '{2'd0, 8'h08, 10'h3FF, 10'h000, 1'b0},
            '{2'd1, 8'h40, 10'h080, 10'h1FF, 1'b1},
            '{2'd1, 8'h20, 10'h100, 10'h1FF, 1'b1},
            '{2'd0, 8'h20, 10'h300, 10'h200, 1'b0},
            '{2'd0, 8'h20, 10'h0FF, 10'h1FE, 1'b0},
            '{2'd2, 8'hFF, 10'h200, 10'h200, 1'b1}
        };
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_stb", out_stb, 0);
        check("rst_out", out_v, 0);
        check("rst_clip", clip, 0);
        rst = 0;

        for (int i = 0; i < 15; i++) apply(vecs[i], $sformatf("vec%0d", i));

        // Strobes while busy (including the DONE cycle) are dropped; mid-flight gain write waits.
        write_gain(8'h10);
        base = stb_cnt;
        for (int k = 0; k <= 20; k++) begin
            @(negedge clk);
            in_stb = (k == 0 || k == 1 || k == 8 || k == 9);
            in_v = (k == 0) ? 10'd100 : 10'd5;
            gain_wr = (k == 3);
            gain_data = 8'h40;
        end
        @(negedge clk);
        in_stb = 0; gain_wr = 0;
        check("ign_count", stb_cnt - base, 1);
        check("ign_out", out_v, 100);
        apply('{2'd0, 8'h40, 10'd50, 10'd200, 1'b0}, "new_gain");

        // Reset during MUL aborts the conversion and restores x1.
        write_gain(8'h20);
        @(negedge clk);
        in_stb = 1; in_v = 10'd77;
        @(negedge clk);
        in_stb = 0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        rst = 1;
        base = stb_cnt;
        @(negedge clk);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_out", out_v, 0);
        check("mid_rst_clip", clip, 0);
        rst = 0; in_stb = 1; in_v = 10'd33;
        @(negedge clk);
        in_stb = 0;
        wait_out(n);
        check("post_rst_lat", n, 9);
        check("post_rst_nostb", stb_cnt - base, 0);
        check("post_rst_out", out_v, 33);

        // Randomized traffic at up to max rate with gain writes at arbitrary times.
        cnt = 0; stb_exp = 0; pend = 8'h10; eo = 0; ec = 0;
        for (int k = 0; k < 800; k++) begin
            @(negedge clk);
            if (k > 0) begin
                check("rnd_busy", busy, cnt != 0);
                check("rnd_stb", out_stb, stb_exp);
                if (stb_exp) begin
                    check("rnd_out", out_v, eo);
                    c_chk = ec;
                    check("rnd_clip", clip, c_chk);
                end
            end
            s  = (k < 780) && ($urandom_range(0, 3) != 0);
            w  = ($urandom_range(0, 4) == 0);
            x  = 10'($urandom);
            gd = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 32)) : 8'($urandom);
            in_stb = s; in_v = x; gain_wr = w; gain_data = gd;
            stb_exp = 0;
            if (cnt == 0 && s) begin
                ref_amp(x, w ? gd : pend, eo, ec);
                cnt = 9;
            end else if (cnt != 0) begin
                cnt--;
                stb_exp = (cnt == 0);
            end
            if (w) pend = gd;
        end
        in_stb = 0; gain_wr = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
